// File: rtl/data_ram_arbiter_pkg.sv
// Shared types for the data RAM arbiter.
// Owner state encodings, master ids and bus width.
package data_ram_arbiter_pkg;

  localparam int REG_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWN_M0 = 2'd1,
    ARB_OWN_M1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_MASTER0 = 1'b0,
    ARB_MASTER1 = 1'b1
  } arb_master_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_pick2.sv
// Combinational winner selection for two masters.
// At most one grant; owner keeps the bus only while locked and under the hold limit.
module data_ram_arbiter_pick2
  import data_ram_arbiter_pkg::*;
(
  input  logic        req0,
  input  logic        req1,
  input  arb_state_t  state,
  input  logic        lock,
  input  logic        hold_ok,
  input  arb_master_t rr_last,
  input  logic        prio,
  output logic        gnt0,
  output logic        gnt1
);

  // Pick the winner from requests, previous owner and fairness state
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      (req0 && !req1): gnt0 = 1'b1;
      (req1 && !req0): gnt1 = 1'b1;
      (req0 && req1): begin
        case (state)
          ARB_OWN_M0: gnt1 = 1'b1;
          ARB_OWN_M1: begin
            if (lock && hold_ok) gnt1 = 1'b1;
            else gnt0 = 1'b1;
          end
          default: begin
            if (prio || rr_last == ARB_MASTER1)
              gnt0 = 1'b1;
            else
              gnt1 = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the CPU data port and a bus master.
// Zero-latency combinational grant, registered owner FSM and contention counter.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int MAX_HOLD    = 8,
  parameter bit M0_PRIORITY = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_ce_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_sel_i,
  input  logic [REG_W-1:0] m0_addr_i,
  input  logic [REG_W-1:0] m0_data_i,
  output logic [REG_W-1:0] m0_data_o,
  output logic             m0_stall_o,
  input  logic             m1_req_i,
  input  logic             m1_lock_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_sel_i,
  input  logic [REG_W-1:0] m1_addr_i,
  input  logic [REG_W-1:0] m1_data_i,
  output logic [REG_W-1:0] m1_data_o,
  output logic             m1_gnt_o,
  output logic             ram_ce_o,
  output logic             ram_we_o,
  output logic [3:0]       ram_sel_o,
  output logic [REG_W-1:0] ram_addr_o,
  output logic [REG_W-1:0] ram_data_o,
  input  logic [REG_W-1:0] ram_data_i,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  arb_state_t  state, state_nxt;
  arb_master_t rr_last, rr_nxt;
  logic [7:0]  hold, hold_nxt;
  logic [CNT_W-1:0] cnt;
  logic gnt0, gnt1;
  logic hold_ok;
  logic both;

  assign hold_ok = hold < HOLD_MAX;
  assign both    = m0_ce_i & m1_req_i;

  data_ram_arbiter_pick2 u_pick (
    .req0    (m0_ce_i),
    .req1    (m1_req_i),
    .state   (state),
    .lock    (m1_lock_i),
    .hold_ok (hold_ok),
    .rr_last (rr_last),
    .prio    (M0_PRIORITY),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  // Owner, hold counter and round-robin pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      hold    <= 8'd0;
      rr_last <= ARB_MASTER1;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      rr_last <= rr_nxt;
    end
  end

  // Next owner follows this cycle's grant
  always_comb begin
    state_nxt = ARB_IDLE;
    hold_nxt  = 8'd0;
    rr_nxt    = rr_last;
    unique case (1'b1)
      gnt0: begin
        state_nxt = ARB_OWN_M0;
        rr_nxt    = ARB_MASTER0;
        hold_nxt  = (state == ARB_OWN_M0) ?
                    sat_inc8(hold) : 8'd1;
      end
      gnt1: begin
        state_nxt = ARB_OWN_M1;
        rr_nxt    = ARB_MASTER1;
        hold_nxt  = (state == ARB_OWN_M1) ?
                    sat_inc8(hold) : 8'd1;
      end
      default: ;
    endcase
  end

  // Saturating count of cycles with both masters requesting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (both && !(&cnt))
      cnt <= cnt + 1'b1;
  end

  // Route the winner onto the RAM port; everything is quiet in reset
  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_sel_o  = 4'd0;
    ram_addr_o = '0;
    ram_data_o = '0;
    m0_data_o  = '0;
    m1_data_o  = '0;
    m0_stall_o = 1'b0;
    m1_gnt_o   = 1'b0;
    if (rst) begin
      m0_stall_o = m0_ce_i & ~gnt0;
      m1_gnt_o   = gnt1;
      unique case (1'b1)
        gnt0: begin
          ram_ce_o   = 1'b1;
          ram_we_o   = m0_we_i;
          ram_sel_o  = m0_sel_i;
          ram_addr_o = m0_addr_i;
          ram_data_o = m0_data_i;
          m0_data_o  = ram_data_i;
        end
        gnt1: begin
          ram_ce_o   = 1'b1;
          ram_we_o   = m1_we_i;
          ram_sel_o  = m1_sel_i;
          ram_addr_o = m1_addr_i;
          ram_data_o = m1_data_i;
          m1_data_o  = ram_data_i;
        end
        default: ;
      endcase
    end
  end

  assign conflict_cnt_o = rst ? cnt : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for the data RAM arbiter.
// Vector table for single-cycle grants, hand sequences for bursts and reset.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_ce, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_addr, m0_wd, m0_rd;
  logic        m0_stall;
  logic        m1_req, m1_lock, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_addr, m1_wd, m1_rd;
  logic        m1_gnt;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wd, ram_rd;
  logic [3:0]  ccnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_ram_arbiter #(
    .MAX_HOLD    (8),
    .M0_PRIORITY (1'b0),
    .CNT_W       (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_ce_i        (m0_ce),
    .m0_we_i        (m0_we),
    .m0_sel_i       (m0_sel),
    .m0_addr_i      (m0_addr),
    .m0_data_i      (m0_wd),
    .m0_data_o      (m0_rd),
    .m0_stall_o     (m0_stall),
    .m1_req_i       (m1_req),
    .m1_lock_i      (m1_lock),
    .m1_we_i        (m1_we),
    .m1_sel_i       (m1_sel),
    .m1_addr_i      (m1_addr),
    .m1_data_i      (m1_wd),
    .m1_data_o      (m1_rd),
    .m1_gnt_o       (m1_gnt),
    .ram_ce_o       (ram_ce),
    .ram_we_o       (ram_we),
    .ram_sel_o      (ram_sel),
    .ram_addr_o     (ram_addr),
    .ram_data_o     (ram_wd),
    .ram_data_i     (ram_rd),
    .conflict_cnt_o (ccnt)
  );

  typedef struct {
    logic        m0_ce;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_gnt;
    logic        e_ce;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c0, input logic w0,
                       input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic l1,
                       input logic w1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [31:0] rd);
    m0_ce   = c0;
    m0_we   = w0;
    m0_sel  = 4'hF;
    m0_addr = a0;
    m0_wd   = d0;
    m1_req  = r1;
    m1_lock = l1;
    m1_we   = w1;
    m1_sel  = 4'h3;
    m1_addr = a1;
    m1_wd   = d1;
    ram_rd  = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ce"}, 32'(ram_ce), 0);
    chk({nm, "_we"}, 32'(ram_we), 0);
    chk({nm, "_sel"}, 32'(ram_sel), 0);
    chk({nm, "_addr"}, ram_addr, 0);
    chk({nm, "_wd"}, ram_wd, 0);
    chk({nm, "_d0"}, m0_rd, 0);
    chk({nm, "_d1"}, m1_rd, 0);
    chk({nm, "_stall"}, 32'(m0_stall), 0);
    chk({nm, "_gnt"}, 32'(m1_gnt), 0);
    chk({nm, "_cnt"}, 32'(ccnt), 0);
  endtask

  function automatic vec_t mk(
    input logic c0, input logic w0, input logic [31:0] a0,
    input logic [31:0] d0, input logic r1, input logic w1,
    input logic [31:0] a1, input logic [31:0] d1,
    input logic [31:0] rd, input logic es, input logic eg,
    input logic ece, input logic ewe, input logic [3:0] esel,
    input logic [31:0] ea, input logic [31:0] ewd,
    input logic [31:0] ed0, input logic [31:0] ed1);
    vec_t v;
    v.m0_ce = c0;  v.m0_we = w0;  v.m0_addr = a0; v.m0_wd = d0;
    v.m1_req = r1; v.m1_we = w1;  v.m1_addr = a1; v.m1_wd = d1;
    v.rdata = rd;  v.e_stall = es; v.e_gnt = eg;  v.e_ce = ece;
    v.e_we = ewe;  v.e_sel = esel; v.e_addr = ea; v.e_wd = ewd;
    v.e_d0 = ed0;  v.e_d1 = ed1;
    return v;
  endfunction

  initial begin
    vt[0] = mk(1, 1, 32'h100, 32'hDEADBEEF, 1, 0, 32'h200, 0,
               32'h11111111, 0, 0, 1, 1, 4'hF, 32'h100,
               32'hDEADBEEF, 32'h11111111, 0);
    vt[1] = mk(0, 0, 0, 0, 1, 0, 32'h100, 0,
               32'hDEADBEEF, 0, 1, 1, 0, 4'h3, 32'h100,
               0, 0, 32'hDEADBEEF);
    vt[2] = mk(1, 0, 32'h104, 0, 1, 1, 32'h204, 32'hCAFE0001,
               32'h22222222, 0, 0, 1, 0, 4'hF, 32'h104,
               0, 32'h22222222, 0);
    vt[3] = mk(1, 0, 32'h104, 0, 1, 1, 32'h204, 32'hCAFE0001,
               32'h33333333, 1, 1, 1, 1, 4'h3, 32'h204,
               32'hCAFE0001, 0, 32'h33333333);
    vt[4] = mk(1, 0, 32'h104, 0, 1, 1, 32'h204, 32'hCAFE0001,
               32'h44444444, 0, 0, 1, 0, 4'hF, 32'h104,
               0, 32'h44444444, 0);
    vt[5] = mk(0, 0, 32'h104, 0, 0, 1, 32'h204, 32'hCAFE0001,
               32'h55555555, 0, 0, 0, 0, 4'h0, 0,
               0, 0, 0);
    vt[6] = mk(1, 0, 32'h104, 0, 1, 1, 32'h204, 32'hCAFE0001,
               32'h66666666, 1, 1, 1, 1, 4'h3, 32'h204,
               32'hCAFE0001, 0, 32'h66666666);
    vt[7] = mk(1, 0, 32'h108, 0, 0, 0, 0, 0,
               32'h77777777, 0, 0, 1, 0, 4'hF, 32'h108,
               0, 32'h77777777, 0);

    // Reset with both masters requesting: everything reads 0
    drive(1, 1, 32'h100, 32'h1234, 1, 1, 1, 32'h200, 32'h5678,
          32'hFFFFFFFF);
    #12;
    chk_all_zero("rst_hold");

    // Vector table from a clean reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vt[i].m0_ce, vt[i].m0_we, vt[i].m0_addr, vt[i].m0_wd,
            vt[i].m1_req, 1'b0, vt[i].m1_we, vt[i].m1_addr,
            vt[i].m1_wd, vt[i].rdata);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(m0_stall), 32'(vt[i].e_stall));
      chk($sformatf("v%0d_gnt", i), 32'(m1_gnt), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d_ce", i), 32'(ram_ce), 32'(vt[i].e_ce));
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d_sel", i), 32'(ram_sel), 32'(vt[i].e_sel));
      chk($sformatf("v%0d_addr", i), ram_addr, vt[i].e_addr);
      chk($sformatf("v%0d_wd", i), ram_wd, vt[i].e_wd);
      chk($sformatf("v%0d_d0", i), m0_rd, vt[i].e_d0);
      chk($sformatf("v%0d_d1", i), m1_rd, vt[i].e_d1);
    end
    @(negedge clk);
    chk("vec_cnt", 32'(ccnt), 5);

    // Locked m1 burst against a waiting m0: 8 grants then m0
    do_reset();
    @(negedge clk);
    drive(1, 0, 32'h10, 0, 0, 0, 0, 32'h20, 0, 0);
    #1;
    chk("burst_pre_stall", 32'(m0_stall), 0);
    chk("burst_pre_gnt", 32'(m1_gnt), 0);
    @(negedge clk);
    drive(1, 0, 32'h10, 0, 1, 1, 0, 32'h20, 0, 0);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("burst%0d_gnt", i), 32'(m1_gnt), 32'(i < 8));
      chk($sformatf("burst%0d_stall", i), 32'(m0_stall), 32'(i < 8));
      @(negedge clk);
    end
    #1;
    chk("burst_regain_gnt", 32'(m1_gnt), 1);
    chk("burst_cnt", 32'(ccnt), 9);

    // Lone locked m1 is never forced off
    do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 0, 32'h40, 0, 0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("solo%0d_gnt", i), 32'(m1_gnt), 1);
      @(negedge clk);
    end
    chk("solo_cnt", 32'(ccnt), 0);

    // Counter saturation, then reset mid-burst
    do_reset();
    @(negedge clk);
    drive(1, 0, 32'h80, 0, 1, 1, 0, 32'h90, 0, 32'hA5A5A5A5);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk($sformatf("sat%0d_cnt", i), 32'(ccnt), (i < 15) ? i : 15);
    end
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_stall", 32'(m0_stall), 0);
    chk("rel_gnt", 32'(m1_gnt), 0);
    chk("rel_ce", 32'(ram_ce), 1);
    chk("rel_addr", ram_addr, 32'h80);
    chk("rel_d0", m0_rd, 32'hA5A5A5A5);
    chk("rel_cnt", 32'(ccnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
